variable_filling_shift_reg: RTL

VARIABLE_FILLING_SHIFT_REG -- requirements
Module: variable_filling_shift_reg

---
 rtl/mapper_pkg.sv | 13 +
 rtl/bit_aligner.sv | 33 +++
 rtl/variable_filling_shift_reg.sv | 100 ++++++++++
 3 files changed

// File: rtl/mapper_pkg.sv
// Shared defaults for the mapper datapath: window width, FIFO word width and
// the bit-buffer sizing rule used by variable_filling_shift_reg.
package mapper_pkg;

   localparam int DEFAULT_MAPPER_PARALLELISM = 8;
   localparam int DEFAULT_IN_WIDTH           = 8;

   // One word may land while up to MAPPER_PARALLELISM-1 bits are still buffered.
   function automatic int calc_buf_w(input int parallelism, input int in_width);
      return parallelism - 1 + in_width;
   endfunction

endpackage

// File: rtl/bit_aligner.sv
// Combinational core of the bit buffer: drops the oldest 'shift' bits, then
// ORs an incoming word in at bit position ins_pos.
module bit_aligner
   import mapper_pkg::*;
#(
   parameter  int MAPPER_PARALLELISM = DEFAULT_MAPPER_PARALLELISM,
   parameter  int IN_WIDTH           = DEFAULT_IN_WIDTH,
   localparam int BUF_W              = calc_buf_w(MAPPER_PARALLELISM, IN_WIDTH),
   localparam int OCC_W              = $clog2(BUF_W + 1),
   localparam int CW                 = $clog2(MAPPER_PARALLELISM + 1)
) (
   input  logic [BUF_W-1:0]    buf_in,
   input  logic [CW-1:0]       shift,
   input  logic                ins_en,
   input  logic [OCC_W-1:0]    ins_pos,
   input  logic [IN_WIDTH-1:0] ins_data,
   output logic [BUF_W-1:0]    buf_out
);

   logic [BUF_W-1:0] shifted;
   logic [BUF_W-1:0] ins_word;

   // Bits above the occupancy are always zero, so a plain OR performs the append.
   always_comb begin
      shifted  = buf_in >> shift;
      ins_word = '0;
      if (ins_en) begin
         ins_word = BUF_W'(ins_data) << ins_pos;
      end
      buf_out = shifted | ins_word;
   end

endmodule

// File: rtl/variable_filling_shift_reg.sv
// Bit-level FIFO refilled from a word FIFO; b shows the oldest MAPPER_PARALLELISM bits.
// Define VFSR_FLUSH_EN to add a synchronous flush input.
module variable_filling_shift_reg
   import mapper_pkg::*;
#(
   parameter  int MAPPER_PARALLELISM = DEFAULT_MAPPER_PARALLELISM,
   parameter  int IN_WIDTH           = DEFAULT_IN_WIDTH,
   localparam int BUF_W              = calc_buf_w(MAPPER_PARALLELISM, IN_WIDTH),
   localparam int OCC_W              = $clog2(BUF_W + 1),
   localparam int CW                 = $clog2(MAPPER_PARALLELISM + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [IN_WIDTH-1:0]           fifo_data,
   input  logic                          fifo_empty,
   output logic                          data_in_fifo_rd_req,
   input  logic [CW-1:0]                 c,
   input  logic                          consume,
`ifdef VFSR_FLUSH_EN
   input  logic                          flush,
`endif
   output logic [MAPPER_PARALLELISM-1:0] b,
   output logic                          b_valid,
   output logic [OCC_W-1:0]              occupancy
);

   localparam logic [OCC_W-1:0] P_OCC  = OCC_W'(MAPPER_PARALLELISM);
   localparam logic [OCC_W-1:0] IN_OCC = OCC_W'(IN_WIDTH);
   localparam logic [CW-1:0]    P_CW   = CW'(MAPPER_PARALLELISM);

   logic [BUF_W-1:0] buf_q, buf_d, aligned;
   logic [OCC_W-1:0] occ_q, occ_d, occ_after;
   logic [OCC_W-1:0] inflight_q, inflight_d;
   logic             arrive_q, arrive_d;
   logic             b_valid_q, b_valid_d;
   logic             accept;
   logic [CW-1:0]    c_clamp, c_eff;
   logic [31:0]      projected;
   logic             rd_req;
   logic             flush_i;

`ifdef VFSR_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   bit_aligner #(
      .MAPPER_PARALLELISM (MAPPER_PARALLELISM),
      .IN_WIDTH           (IN_WIDTH)
   ) u_bit_aligner (
      .buf_in   (buf_q),
      .shift    (c_eff),
      .ins_en   (arrive_q),
      .ins_pos  (occ_after),
      .ins_data (fifo_data),
      .buf_out  (aligned)
   );

   // Consume first, then append; reads are sized against what is already in flight.
   always_comb begin
      accept     = consume & b_valid_q;
      c_clamp    = (c > P_CW) ? P_CW : c;
      c_eff      = accept ? c_clamp : '0;
      occ_after  = occ_q - OCC_W'(c_eff);
      projected  = 32'(occ_after) + 32'(IN_WIDTH) * 32'(inflight_q);
      rd_req     = reset & ~fifo_empty & ~flush_i & (projected < 32'(MAPPER_PARALLELISM));
      arrive_d   = rd_req;
      inflight_d = inflight_q + OCC_W'(rd_req) - OCC_W'(arrive_q);
      occ_d      = occ_after + (arrive_q ? IN_OCC : '0);
      buf_d      = aligned;
      if (flush_i) begin
         occ_d = '0;
         buf_d = '0;
      end
      b_valid_d  = (occ_d >= P_OCC);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q      <= '0;
         occ_q      <= '0;
         inflight_q <= '0;
         arrive_q   <= 1'b0;
         b_valid_q  <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         arrive_q   <= arrive_d;
         b_valid_q  <= b_valid_d;
      end
   end

   assign data_in_fifo_rd_req = rd_req;
   assign b                   = buf_q[MAPPER_PARALLELISM-1:0];
   assign b_valid             = b_valid_q;
   assign occupancy           = occ_q;

endmodule
